// File: rtl/theia_core.sv
// Theia control core: runs a preloaded instruction RAM and moves main-memory words into per-core data RAMs.
// Defining THEIA_CORE_STATUS_EN adds the oPC and oHalted status outputs.

module theia_core_iram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    output logic [31:0]   rdata_o
);
    // Read-only at run time; contents arrive by hierarchical preload.
    logic [31:0] Ram [DEPTH];

    always_ff @(posedge clk_i) rdata_o <= Ram[addr_i];
endmodule

module theia_core #(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned IRAM_DEPTH = 64,
    parameter int unsigned CRAM_DEPTH = 64
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iEnable,
    input  logic [31:0] iMemReadData,
    input  logic        iMemDataAvailable,
    output logic        oMEM_ReadRequest,
    output logic [31:0] oMemReadAddress
`ifdef THEIA_CORE_STATUS_EN
  , output logic [5:0]  oPC,
    output logic        oHalted
`endif
);
    localparam int unsigned PC_W  = 6;
    localparam int unsigned MA_W  = 14;
    localparam int unsigned LEN_W = 6;
    localparam int unsigned OFF_W = $clog2(CRAM_DEPTH);

    typedef enum logic [2:0] {FETCH, EXEC, REQ, WAIT, HALT} state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;     // words to move minus one
    logic [LEN_W-1:0]  dst_q, dst_d;
    logic [MA_W-1:0]   src_q, src_d;
    logic [1:0]        core_q, core_d;
    logic              req_q, req_d;
    logic [MA_W-1:0]   addr_q, addr_d;
    logic [31:0]       instr;
    logic              wr_en_c;
    logic [OFF_W-1:0]  wr_off;

    logic [31:0] core_ram [NUM_CORES][CRAM_DEPTH];

    theia_core_iram #(
        .DEPTH (IRAM_DEPTH),
        .AW    (PC_W)
    ) InstructionRam (
        .clk_i   (Clock),
        .addr_i  (pc_q),
        .rdata_o (instr)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            core_q  <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            core_q  <= core_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        dst_d   = dst_q;
        src_d   = src_q;
        core_d  = core_q;
        req_d   = 1'b0;
        addr_d  = addr_q;
        wr_en_c = 1'b0;
        case (state_q)
            FETCH: if (iEnable) state_d = EXEC;
            EXEC: begin
                case (instr[31:28])
                    4'h1: begin
                        core_d  = instr[27:26];
                        dst_d   = instr[25:20];
                        len_d   = instr[19:14];
                        src_d   = instr[13:0];
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        addr_d  = instr[13:0];
                        state_d = REQ;
                    end
                    4'h2: begin
                        pc_d    = instr[5:0];
                        state_d = FETCH;
                    end
                    4'hF: state_d = HALT;
                    default: begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = FETCH;
                    end
                endcase
            end
            REQ: state_d = WAIT;
            WAIT: begin
                // Address stays in addr_q until the word is taken here.
                if (iMemDataAvailable) begin
                    wr_en_c = 1'b1;
                    if (cnt_q == len_q) begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = FETCH;
                    end else begin
                        cnt_d   = cnt_q + LEN_W'(1);
                        req_d   = 1'b1;
                        addr_d  = src_q + MA_W'(cnt_d);
                        state_d = REQ;
                    end
                end
            end
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    assign wr_off = OFF_W'((32'(dst_q) + 32'(cnt_q)) % CRAM_DEPTH);

    // Core index beyond NUM_CORES matches no RAM, so those words are dropped.
    always_ff @(posedge Clock) begin
        if (wr_en_c) begin
            for (int c = 0; c < NUM_CORES; c++) begin
                if (int'(core_q) == c) core_ram[c][wr_off] <= iMemReadData;
            end
        end
    end

    assign oMEM_ReadRequest = req_q;
    assign oMemReadAddress  = {(32 - MA_W)'(0), addr_q};

`ifdef THEIA_CORE_STATUS_EN
    logic halted_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) halted_q <= 1'b0;
        else       halted_q <= (state_d == HALT);
    end

    assign oPC     = pc_q;
    assign oHalted = halted_q;
`endif
endmodule

// File: tb/tb_theia_core.sv
// Bench for theia_core: directed programs plus random ones, checked against an instruction-level model
// with a main-memory responder of configurable latency.

module tb_theia_core;
    localparam int NC = 3;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iEnable;
    logic [31:0] iMemReadData;
    logic        iMemDataAvailable;
    logic        oMEM_ReadRequest;
    logic [31:0] oMemReadAddress;
`ifdef THEIA_CORE_STATUS_EN
    logic [5:0]  oPC;
    logic        oHalted;
`endif

    theia_core #(.NUM_CORES(NC)) dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .iEnable           (iEnable),
        .iMemReadData      (iMemReadData),
        .iMemDataAvailable (iMemDataAvailable),
        .oMEM_ReadRequest  (oMEM_ReadRequest),
        .oMemReadAddress   (oMemReadAddress)
`ifdef THEIA_CORE_STATUS_EN
      , .oPC               (oPC),
        .oHalted           (oHalted)
`endif
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [13:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Main-memory responder and protocol monitors
    int          mem_lat = 1;
    bit          pending = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    bit          prev_req = 0;
    bit          stray = 0;
    bit          en_rand = 0;
    int          pulse_err = 0;
    int          hold_err = 0;
    int          outst_err = 0;
    int          avail_cnt = 0;
    int          cyc = 0;
    logic [31:0] req_log[$];
    int          req_cyc[$];

    always @(posedge Clock) cyc++;

    always @(negedge Clock) begin
        iMemDataAvailable = 1'b0;
        iMemReadData = $urandom;
        if (stray) begin
            iMemDataAvailable = 1'b1;
            stray = 0;
        end else if (pending) begin
            if (pend_cnt <= 1) begin
                iMemDataAvailable = 1'b1;
                iMemReadData = mem_word(pend_addr[13:0]);
                pending = 0;
                avail_cnt++;
            end else begin
                pend_cnt--;
            end
        end
        if (oMEM_ReadRequest) begin
            if (prev_req) pulse_err++;
            if (pending) outst_err++;
            req_log.push_back(oMemReadAddress);
            req_cyc.push_back(cyc);
            pending = 1;
            pend_cnt = mem_lat;
            pend_addr = oMemReadAddress;
        end else if (pending && oMemReadAddress !== pend_addr) begin
            hold_err++;
        end
        prev_req = oMEM_ReadRequest;
        if (en_rand) iEnable = ($urandom_range(0, 3) != 0);
    end

    // Instruction-level reference model
    logic [31:0] iram [64];
    logic [31:0] exp_core [4][64];
    logic [31:0] exp_addrs[$];

    task automatic model_exec();
        int pc = 0;
        exp_addrs.delete();
        for (int step = 0; step < 1000; step++) begin
            logic [31:0] ins = iram[pc];
            case (ins[31:28])
                4'h1: begin
                    int core = int'(ins[27:26]);
                    int dst  = int'(ins[25:20]);
                    int n    = int'(ins[19:14]) + 1;
                    int src  = int'(ins[13:0]);
                    for (int i = 0; i < n; i++) begin
                        int a = (src + i) % 16384;
                        exp_addrs.push_back(32'(a));
                        if (core < NC) exp_core[core][(dst + i) % 64] = mem_word(14'(a));
                    end
                    pc = (pc + 1) % 64;
                end
                4'h2: pc = int'(ins[5:0]);
                4'hF: return;
                default: pc = (pc + 1) % 64;
            endcase
        end
    endtask

    function automatic logic [31:0] ld(input int core, input int dst, input int len, input int src);
        return {4'h1, 2'(core), 6'(dst), 6'(len - 1), 14'(src)};
    endfunction

    function automatic logic [31:0] jmp(input int t);
        return {4'h2, 22'h0, 6'(t)};
    endfunction

    task automatic fill_halt();
        for (int i = 0; i < 64; i++) iram[i] = 32'hF000_0000;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++) dut.InstructionRam.Ram[i] = iram[i];
    endtask

    task automatic clear_logs();
        req_log.delete();
        req_cyc.delete();
        pulse_err = 0;
        hold_err = 0;
        outst_err = 0;
        avail_cnt = 0;
    endtask

    task automatic check_ram(input string tag);
        int bad = 0;
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < 64; i++)
                if (dut.core_ram[c][i] !== exp_core[c][i]) bad++;
        check({tag, "_ram_bad_words"}, 32'(bad), 32'd0);
    endtask

    task automatic start_run(input int lat);
        @(negedge Clock);
        Reset = 1'b1;
        iEnable = 1'b0;
        mem_lat = lat;
        pending = 0;
        clear_logs();
        @(negedge Clock);
        Reset = 1'b0;
        iEnable = 1'b1;
    endtask

    task automatic finish_run(input string tag);
        int budget = 0;
        while (!(req_log.size() >= exp_addrs.size() && !pending) && budget < 3000) begin
            @(negedge Clock);
            budget++;
        end
        check({tag, "_timeout"}, 32'(budget >= 3000), 32'd0);
        repeat (15) @(negedge Clock);
        en_rand = 0;
        iEnable = 1'b1;
        check({tag, "_nreq"}, 32'(req_log.size()), 32'(exp_addrs.size()));
        for (int i = 0; i < exp_addrs.size() && i < req_log.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), req_log[i], exp_addrs[i]);
        check({tag, "_pulse"}, 32'(pulse_err), 32'd0);
        check({tag, "_hold"}, 32'(hold_err), 32'd0);
        check({tag, "_outstanding"}, 32'(outst_err), 32'd0);
        check_ram(tag);
`ifdef THEIA_CORE_STATUS_EN
        check({tag, "_halted"}, 32'(oHalted), 32'd1);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        Reset = 1'b1;
        iEnable = 1'b0;
        iMemReadData = '0;
        iMemDataAvailable = 1'b0;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 64; i++) exp_core[c][i] = 32'hDEAD_0000 | 32'(c << 8) | 32'(i);
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < 64; i++) dut.core_ram[c][i] = exp_core[c][i];
        fill_halt();
        iram[0] = 32'h1000_C005;
        load_prog();
        #1;
        check("rst_req", 32'(oMEM_ReadRequest), 32'd0);
        check("rst_addr", oMemReadAddress, 32'd0);

        // Held off by iEnable=0: nothing may happen
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        clear_logs();
        repeat (100) @(negedge Clock);
        check("idle_nreq", 32'(req_log.size()), 32'd0);
        check("idle_addr", oMemReadAddress, 32'd0);
        check_ram("idle");

        // Same LOAD now allowed to run, one-cycle memory
        mem_lat = 1;
        iEnable = 1'b1;
        model_exec();
        finish_run("t2");
        if (req_cyc.size() >= 4) check("t2_span", 32'(req_cyc[3] - req_cyc[0]), 32'd6);
        else check("t2_span_nreq", 32'(req_cyc.size()), 32'd4);

        // Slow memory: five cycles of latency
        start_run(5);
        model_exec();
        finish_run("t3");
        if (req_cyc.size() >= 4) check("t3_span", 32'(req_cyc[3] - req_cyc[0]), 32'd18);
        else check("t3_span_nreq", 32'(req_cyc.size()), 32'd4);

        // Jump over a LOAD straight to HALT
        fill_halt();
        iram[0] = jmp(3);
        iram[1] = ld(1, 0, 4, 32);
        iram[2] = 32'h0;
        load_prog();
        start_run(1);
        model_exec();
        finish_run("t4");

        // Source and destination wrap-around
        fill_halt();
        iram[0] = ld(0, 62, 4, 16383);
        load_prog();
        start_run(2);
        model_exec();
        finish_run("t5");
        check("t5_off62", dut.core_ram[0][62], mem_word(14'h3FFF));
        check("t5_off63", dut.core_ram[0][63], mem_word(14'h0000));
        check("t5_off0", dut.core_ram[0][0], mem_word(14'h0001));
        check("t5_off1", dut.core_ram[0][1], mem_word(14'h0002));

        // Reset in the middle of a LOAD
        fill_halt();
        iram[0] = ld(1, 10, 4, 5);
        load_prog();
        start_run(1);
        budget = 0;
        while (avail_cnt < 2 && budget < 200) begin
            @(negedge Clock);
            budget++;
        end
        check("t6_wait2", 32'(avail_cnt >= 2), 32'd1);
        @(posedge Clock);
        #3;
        Reset = 1'b1;
        iEnable = 1'b0;
        #1;
        check("t6_rst_req", 32'(oMEM_ReadRequest), 32'd0);
        check("t6_rst_addr", oMemReadAddress, 32'd0);
        exp_core[1][10] = mem_word(14'd5);
        exp_core[1][11] = mem_word(14'd6);
        check_ram("t6_abort");
        @(negedge Clock);
        Reset = 1'b0;
        pending = 0;
        clear_logs();
        stray = 1;
        repeat (4) @(negedge Clock);
        check("t6_stray_nreq", 32'(req_log.size()), 32'd0);
        check_ram("t6_stray");
        iEnable = 1'b1;
        model_exec();
        finish_run("t6");

        // Random programs with forward-only jumps, random latency and iEnable jitter
        for (int t = 0; t < 8; t++) begin
            int n;
            fill_halt();
            n = $urandom_range(2, 8);
            for (int pc = 0; pc < n; pc++) begin
                int r = $urandom_range(0, 9);
                if (r < 6) begin
                    int src = ($urandom_range(0, 1) != 0) ? 16380 + $urandom_range(0, 3)
                                                          : $urandom_range(0, 16383);
                    iram[pc] = ld($urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(1, 6), src);
                end else if (r == 6) begin
                    iram[pc] = {4'($urandom_range(3, 14)), 28'($urandom)};
                end else if (r == 7) begin
                    iram[pc] = jmp($urandom_range(pc + 1, n));
                end else begin
                    iram[pc] = 32'h0;
                end
            end
            load_prog();
            start_run($urandom_range(1, 5));
            en_rand = (t % 2) == 1;
            model_exec();
            finish_run($sformatf("rnd%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/theia_core.md
THEIA_CORE -- requirements
Module: theia_core

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: number of vector-core data RAMs (1..4).
REQ-002 SHALL have parameter IRAM_DEPTH, default 64: control instruction RAM words (32-bit); the PC is 6 bits wide.
REQ-003 SHALL have parameter CRAM_DEPTH, default 64: 32-bit words per core data RAM.
REQ-004 SHALL have port Clock, input, 1: the single clock, rising edge.
REQ-005 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port iEnable, input, 1: run permission for the controller.
REQ-007 SHALL have port iMemReadData, input, 32: main-memory read data.
REQ-008 SHALL have port iMemDataAvailable, input, 1: iMemReadData valid this cycle.
REQ-009 SHALL have port oMEM_ReadRequest, output, 1: main-memory read request pulse.
REQ-010 SHALL have port oMemReadAddress, output, 32: word address of the request, zero-extended from 14 bits.

Function
REQ-011 SHALL contain a synchronous-read instruction RAM named InstructionRam, word array Ram, loadable by hierarchical preload; it has no write port.
REQ-012 SHALL contain NUM_CORES data RAMs, written only by LOAD and readable hierarchically.
REQ-013 Controller states SHALL be FETCH, EXEC, REQ, WAIT and HALT; reset enters FETCH.
REQ-014 FETCH SHALL present PC to InstructionRam and move to EXEC only when iEnable=1; with iEnable=0 it holds, so new instructions start only at instruction boundaries.
REQ-015 Opcode [31:28] 0x0 (NOP) SHALL do PC+1, then FETCH.
REQ-016 Opcode 0x1 (LOAD) SHALL copy [19:14]+1 words from main address [13:0] to core [27:26], offset [25:20].
REQ-017 Opcode 0x2 (JUMP) SHALL set PC=[5:0], then FETCH.
REQ-018 Opcode 0xF (HALT) SHALL enter HALT, leaving it only by Reset; other opcodes SHALL act as NOP.
REQ-019 LOAD to a core index >= NUM_CORES SHALL perform all memory reads but discard the writes.
REQ-020 REQ SHALL drive oMEM_ReadRequest=1 for exactly one cycle with address = (src+i) mod 2^14, then enter WAIT.
REQ-021 oMemReadAddress SHALL stay stable from the REQ cycle until the data is accepted.
REQ-022 WAIT SHALL hold, with no request, until iMemDataAvailable=1.
REQ-023 On that cycle, WAIT SHALL write iMemReadData to offset (dst+i) mod CRAM_DEPTH, then issue the next REQ, or do PC+1 and FETCH after the last word.
REQ-024 At most one read SHALL be outstanding; iMemDataAvailable outside WAIT SHALL be ignored.
REQ-025 A word SHALL cost 2 cycles when the memory answers on the cycle after the request.
REQ-026 iEnable deassertion during a LOAD SHALL NOT stall the transfer in progress.
REQ-027 PC SHALL wrap 63 to 0.

Reset
REQ-028 Reset SHALL immediately force oMEM_ReadRequest=0, oMemReadAddress=0, PC=0, word counter=0 and state FETCH.
REQ-029 Reset SHALL NOT clear the instruction RAM or core RAMs.
REQ-030 Reset during a LOAD SHALL abort it; a late iMemDataAvailable SHALL be ignored.

Configuration
REQ-031 With THEIA_CORE_STATUS_EN defined, SHALL add outputs oPC (6 bits, current PC) and oHalted (1 in HALT); both reset to 0.
REQ-032 Without THEIA_CORE_STATUS_EN, those ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 iEnable=0 for 100 cycles after reset -> oMEM_ReadRequest stays 0, address 0, no RAM changes.
REQ-034 IRAM[0]=0x1000C005 (LOAD core0, dst 0, len 4, src 5), IRAM[1]=0xF0000000, one-cycle-latency memory, iEnable=1 -> reads 5..8 in order, core0[0..3]=mem[5..8], 8 cycles of transfer, then HALT.
REQ-035 Memory answers 5 cycles late -> request stays a single-cycle pulse, address held, same final RAM contents.
REQ-036 JUMP to 3 at IRAM[0], HALT at IRAM[3], LOAD at IRAM[1] -> no memory request is ever issued.
REQ-037 LOAD dst 62, len 4, src 0x3FFF -> addresses 0x3FFF,0,1,2; writes to offsets 62,63,0,1.
REQ-038 Reset asserted mid-LOAD, after 2 words -> outputs 0 at once; after release, execution restarts at PC=0 and the 2 written words remain.
